// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: address width and the
// redirect-kind encodings presented by the decode stage.
package fetch_sequencer_pkg;

   localparam int ADDR_W = 16;

   typedef logic [ADDR_W-1:0] addr_t;

   localparam logic [1:0] KIND_JUMP = 2'b00;
   localparam logic [1:0] KIND_CALL = 2'b01;
   localparam logic [1:0] KIND_RET  = 2'b10;
   localparam logic [1:0] KIND_RSVD = 2'b11;

endpackage

// File: rtl/return_addr_stack.sv
// Return-address stack: circular buffer with a saturating occupancy count.
// A push onto a full stack overwrites the oldest entry; a pop of an empty
// stack changes nothing. Both cases raise a single-cycle pulse.
// Ports:
//   clock, reset        clock and synchronous active-high reset
//   push, push_data     write a link address on top of the stack
//   pop                 discard the top entry
//   top_data            current top entry (valid when count != 0)
//   count               number of valid entries, 0..RAS_DEPTH
//   overflow, underflow pulses for push-when-full / pop-when-empty
module return_addr_stack
   import fetch_sequencer_pkg::*;
#(
   parameter  int RAS_DEPTH = 4,
   localparam int PTR_W     = $clog2(RAS_DEPTH),
   localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  addr_t            push_data,
   output addr_t            top_data,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             underflow
);

   addr_t            mem_q [RAS_DEPTH];
   addr_t            mem_d [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_dec;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full, empty;

   // ptr_q is the next free slot; the top lives one below it. Power-of-two
   // depth lets the pointer wrap without an explicit modulo.
   assign ptr_dec   = ptr_q - PTR_W'(1);
   assign top_data  = mem_q[ptr_dec];
   assign count     = count_q;
   assign full      = (count_q == CNT_W'(RAS_DEPTH));
   assign empty     = (count_q == '0);
   assign overflow  = push & full;
   assign underflow = pop & empty;

   always_comb begin
      mem_d   = mem_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      if (push) begin
         mem_d[ptr_q] = push_data;
         ptr_d        = ptr_q + PTR_W'(1);
         if (!full) count_d = count_q + CNT_W'(1);
      end else if (pop && !empty) begin
         ptr_d   = ptr_dec;
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter controller for a synchronous-read instruction memory with
// one cycle of read latency. Drives the memory address every cycle, holds on
// decode stalls and applies JUMP/CALL/RET redirects with no bubble.
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   stall                        decode cannot take the held instruction
//   redirect_valid/kind/target   control-flow change for the word at fetch_pc
//   AddressBus                   memory address (combinational from inputs)
//   fetch_pc, fetch_valid        origin and validity of the memory output word
//   ras_overflow, ras_underflow  sticky return-stack error flags
// The stall/redirect -> AddressBus path is combinational by design; timing
// closure must budget decode logic plus this mux into the memory address setup.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter addr_t RESET_PC  = 16'h0000,
   parameter int    RAS_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [1:0]  redirect_kind,
   input  addr_t       redirect_target,
   output addr_t       AddressBus,
   output addr_t       fetch_pc,
   output logic        fetch_valid,
   output logic        ras_overflow,
   output logic        ras_underflow
);

   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   addr_t            pc_q, pc_d;
   addr_t            fetch_pc_q, fetch_pc_d;
   logic             fetch_valid_q, fetch_valid_d;
   logic             ras_overflow_q, ras_overflow_d;
   logic             ras_underflow_q, ras_underflow_d;

   logic             stall_e, redir_e, ras_push, ras_pop;
   addr_t            next_addr, link_addr, ras_top;
   logic [CNT_W-1:0] ras_count;
   logic             ras_ovf_pulse, ras_udf_pulse;

   // A stall without a held instruction has nothing to protect.
   assign stall_e   = stall & fetch_valid_q;
   assign redir_e   = redirect_valid & ~stall_e & (redirect_kind != KIND_RSVD);
   assign ras_push  = redir_e & (redirect_kind == KIND_CALL);
   assign ras_pop   = redir_e & (redirect_kind == KIND_RET);
   assign link_addr = fetch_pc_q + addr_t'(1);

   return_addr_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clock     (clock),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (link_addr),
      .top_data  (ras_top),
      .count     (ras_count),
      .overflow  (ras_ovf_pulse),
      .underflow (ras_udf_pulse)
   );

   always_comb begin
      next_addr = pc_q;
      if (reset) begin
         next_addr = RESET_PC;
      end else if (stall_e) begin
         // Re-read the held word so the memory output register keeps it.
         next_addr = fetch_pc_q;
      end else if (redir_e && (redirect_kind == KIND_JUMP || redirect_kind == KIND_CALL)) begin
         next_addr = redirect_target;
      end else if (ras_pop) begin
         next_addr = (ras_count != '0) ? ras_top : link_addr;
      end
   end

   assign AddressBus = next_addr;

   always_comb begin
      pc_d            = next_addr + addr_t'(1);
      fetch_pc_d      = next_addr;
      fetch_valid_d   = 1'b1;
      ras_overflow_d  = ras_overflow_q | ras_ovf_pulse;
      ras_underflow_d = ras_underflow_q | ras_udf_pulse;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q            <= RESET_PC;
         fetch_pc_q      <= RESET_PC;
         fetch_valid_q   <= 1'b0;
         ras_overflow_q  <= 1'b0;
         ras_underflow_q <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         fetch_pc_q      <= fetch_pc_d;
         fetch_valid_q   <= fetch_valid_d;
         ras_overflow_q  <= ras_overflow_d;
         ras_underflow_q <= ras_underflow_d;
      end
   end

   assign fetch_pc      = fetch_pc_q;
   assign fetch_valid   = fetch_valid_q;
   assign ras_overflow  = ras_overflow_q;
   assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [1:0]  redirect_kind;
   logic [15:0] redirect_target;
   logic [15:0] AddressBus;
   logic [15:0] fetch_pc;
   logic        fetch_valid;
   logic        ras_overflow;
   logic        ras_underflow;

   int checks   = 0;
   int failures = 0;

   fetch_sequencer #(.RESET_PC(16'h0000), .RAS_DEPTH(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_kind   (redirect_kind),
      .redirect_target (redirect_target),
      .AddressBus      (AddressBus),
      .fetch_pc        (fetch_pc),
      .fetch_valid     (fetch_valid),
      .ras_overflow    (ras_overflow),
      .ras_underflow   (ras_underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic st, input logic rv, input logic [1:0] k, input logic [15:0] t);
      stall           = st;
      redirect_valid  = rv;
      redirect_kind   = k;
      redirect_target = t;
   endtask

   // Apply a redirect for one cycle, check the same-cycle address, then the
   // fetched pc after the edge.
   task automatic redir_step(input string tag, input logic [1:0] k, input logic [15:0] t,
                             input logic [15:0] exp_addr);
      drive(1'b0, 1'b1, k, t);
      #1;
      chk({tag, "_addr"}, AddressBus, exp_addr);
      tick();
      chk({tag, "_fpc"}, fetch_pc, exp_addr);
      drive(1'b0, 1'b0, KIND_JUMP, 16'h0);
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, KIND_JUMP, 16'h0);
      tick();
      tick();
      chk("rst_valid", fetch_valid, 0);
      chk("rst_fpc", fetch_pc, 16'h0000);
      chk("rst_addr", AddressBus, 16'h0000);
      chk("rst_ovf", ras_overflow, 0);
      chk("rst_udf", ras_underflow, 0);

      // Sequential fetch from reset.
      reset = 1'b0;
      #1;
      for (int i = 0; i < 6; i++) begin
         chk("seq_addr", AddressBus, i);
         tick();
         chk("seq_fpc", fetch_pc, i);
         chk("seq_valid", fetch_valid, 1);
      end

      // Stall three cycles at fetch_pc=5.
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_addr", AddressBus, 16'd5);
         tick();
         chk("stall_fpc", fetch_pc, 16'd5);
      end
      stall = 1'b0;
      #1;
      chk("unstall_addr", AddressBus, 16'd6);
      tick();
      chk("unstall_fpc", fetch_pc, 16'd6);
      tick();
      tick();
      tick();
      chk("pre_jump_fpc", fetch_pc, 16'd9);

      // Jump, then call/return.
      redir_step("jump", KIND_JUMP, 16'd17, 16'd17);
      tick();
      chk("jump_seq", fetch_pc, 16'd18);
      redir_step("call1", KIND_CALL, 16'd20, 16'd20);
      redir_step("ret1", KIND_RET, 16'h0, 16'd19);
      chk("ret1_ovf", ras_overflow, 0);
      chk("ret1_udf", ras_underflow, 0);

      // Five calls overflow a 4-deep stack; the oldest link (20) is lost.
      redir_step("callA", KIND_CALL, 16'd100, 16'd100);
      redir_step("callB", KIND_CALL, 16'd200, 16'd200);
      redir_step("callC", KIND_CALL, 16'd300, 16'd300);
      redir_step("callD", KIND_CALL, 16'd400, 16'd400);
      chk("pre_ovf", ras_overflow, 0);
      redir_step("callE", KIND_CALL, 16'd500, 16'd500);
      chk("ovf_set", ras_overflow, 1);
      redir_step("retE", KIND_RET, 16'h0, 16'd401);
      redir_step("retD", KIND_RET, 16'h0, 16'd301);
      redir_step("retC", KIND_RET, 16'h0, 16'd201);
      redir_step("retB", KIND_RET, 16'h0, 16'd101);
      chk("pre_udf", ras_underflow, 0);
      redir_step("retEmpty", KIND_RET, 16'h0, 16'd102);
      chk("udf_set", ras_underflow, 1);

      // Stall beats redirect: a stalled RET must not pop.
      redir_step("call50", KIND_CALL, 16'd50, 16'd50);
      drive(1'b1, 1'b1, KIND_RET, 16'h0);
      #1;
      chk("stallret_addr", AddressBus, 16'd50);
      tick();
      chk("stallret_fpc", fetch_pc, 16'd50);
      drive(1'b1, 1'b1, KIND_JUMP, 16'd77);
      #1;
      chk("stalljmp_addr", AddressBus, 16'd50);
      tick();
      drive(1'b0, 1'b0, KIND_JUMP, 16'h0);
      #1;
      chk("post_stall_addr", AddressBus, 16'd51);
      tick();
      redir_step("ret_kept", KIND_RET, 16'h0, 16'd103);
      redir_step("rsvd", KIND_RSVD, 16'd7, 16'd104);

      // 16-bit wrap of pc_q and of the link address.
      redir_step("jmpFFFF", KIND_JUMP, 16'hFFFF, 16'hFFFF);
      #1;
      chk("wrap_addr", AddressBus, 16'h0000);
      tick();
      chk("wrap_fpc", fetch_pc, 16'h0000);
      redir_step("jmpFFFF2", KIND_JUMP, 16'hFFFF, 16'hFFFF);
      redir_step("call_wrap", KIND_CALL, 16'd30, 16'd30);
      redir_step("ret_wrap", KIND_RET, 16'h0, 16'h0000);

      // Reset mid-sequence with a pending redirect and a non-empty stack.
      redir_step("call60", KIND_CALL, 16'd60, 16'd60);
      redir_step("jmpFFFF3", KIND_JUMP, 16'hFFFF, 16'hFFFF);
      reset = 1'b1;
      drive(1'b0, 1'b1, KIND_JUMP, 16'd40);
      #1;
      chk("mid_rst_addr", AddressBus, 16'h0000);
      tick();
      chk("mid_rst_fpc", fetch_pc, 16'h0000);
      chk("mid_rst_valid", fetch_valid, 0);
      chk("mid_rst_ovf", ras_overflow, 0);
      chk("mid_rst_udf", ras_underflow, 0);
      reset = 1'b0;
      drive(1'b0, 1'b0, KIND_JUMP, 16'h0);
      #1;
      chk("restart_addr", AddressBus, 16'h0000);
      tick();
      chk("restart_fpc", fetch_pc, 16'h0000);
      chk("restart_valid", fetch_valid, 1);
      tick();
      redir_step("ret_after_rst", KIND_RET, 16'h0, 16'd2);
      chk("udf_after_rst", ras_underflow, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter controller that sequences the 16-bit synchronous-read instruction memory (one-cycle read latency, 256 words populated). It drives the memory address each cycle and honours decode-stage stalls and redirects (jump, branch, call, return) with zero bubble. A small return-address stack serves CALL/RET. It reports which address the instruction currently in the memory's output register came from, and whether that instruction is valid.

## Interface
- RESET_PC, 16'h0000, first address fetched after reset
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16)
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  decode cannot accept the current instruction; hold it
- redirect_valid  in  1  decode requests a control-flow change for the instruction at fetch_pc
- redirect_kind  in  2  00 JUMP/taken branch, 01 CALL, 10 RET, 11 reserved (ignored)
- redirect_target  in  16  absolute target for JUMP/CALL; ignored for RET
- AddressBus  out  16  address to instruction memory (combinational)
- fetch_pc  out  16  address of the word now in the memory output register
- fetch_valid  out  1  memory output register holds a valid instruction
- ras_overflow  out  1  sticky: CALL pushed onto a full stack
- ras_underflow  out  1  sticky: RET popped an empty stack

## Operation
- State: pc_q (next sequential address), fetch_pc_q, fetch_valid_q, RAS (circular buffer plus saturating count 0..RAS_DEPTH), two sticky flags.
- Effective stall: stall_e = stall & fetch_valid_q. stall is ignored while no valid instruction is held.
- Effective redirect: redir_e = redirect_valid & ~stall_e & (redirect_kind != 11). Stall has priority. The decoder re-asserts a redirect after the stall clears.
- next_addr, in priority order:
  - reset: RESET_PC
  - stall_e: fetch_pc_q (re-read the held word so the memory output register is not clobbered)
  - redir_e JUMP/CALL: redirect_target
  - redir_e RET: RAS top if count > 0, else fetch_pc_q+1
  - otherwise: pc_q
- AddressBus = next_addr.
- Rising edge with reset high: pc_q <= RESET_PC, fetch_pc_q <= RESET_PC, fetch_valid_q <= 0, RAS count <= 0, pointer <= 0, both flags <= 0.
- Rising edge otherwise: pc_q <= next_addr+1, fetch_pc_q <= next_addr, fetch_valid_q <= 1.
- Arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000, for both pc_q and the link address.
- CALL (redir_e) pushes fetch_pc_q+1.
  - Full stack: the oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow <= 1.
- RET (redir_e) pops.
  - Empty stack: no pop, ras_underflow <= 1, falls through to fetch_pc_q+1.
- A stalled or reserved-kind redirect changes neither the RAS nor the flags.

## Timing
- Reset values: fetch_valid=0, fetch_pc=RESET_PC, AddressBus=RESET_PC while reset is high, flags=0.
- First edge after reset deasserts: memory output = mem[RESET_PC], fetch_pc=RESET_PC, fetch_valid=1.
- Sequential fetch: one instruction per cycle, fetch_pc increments each edge.
- Redirect: the target is driven on AddressBus in the same cycle. The target instruction is in the memory output register one edge later, with no bubble and nothing to flush.
- Stall: fetch_pc and the memory output are unchanged for each cycle stall is held. Fetch resumes at pc_q on the first cycle after stall drops.
- Reset mid-operation: all state returns to reset values on that edge, including the RAS contents-count and the sticky flags.
- Combinational path from redirect_*/stall to AddressBus is accepted and documented for timing closure.

## Structure
- Shared package/header holds the redirect-kind encodings (KIND_JUMP=2'b00, KIND_CALL=2'b01, KIND_RET=2'b10, KIND_RSVD=2'b11) and the 16-bit address width constant.
- One sub-module, return_addr_stack: push/pop/data/count, overflow/underflow pulses, parameterised by RAS_DEPTH.
- The top level holds the PC registers and the next_addr mux.

## Test plan
- Reset with RESET_PC=0, release, no stall -> AddressBus 0,1,2,3 on successive cycles; fetch_pc 0,1,2 one edge behind; fetch_valid rises after the first edge.
- Stall high for 3 cycles while fetch_pc=5 -> AddressBus=5 and fetch_pc=5 held for 3 cycles; next fetch_pc=6.
- JUMP to 17 while fetch_pc=9 -> AddressBus=17 that cycle; next fetch_pc=17, then 18.
- CALL 20 at fetch_pc=18, then RET at fetch_pc=20 -> fetch_pc goes 20, then 19; no flags set.
- Five CALLs with RAS_DEPTH=4 -> ras_overflow=1. Then five RETs -> four correct returns, then ras_underflow=1 and fall-through to fetch_pc+1.
- Assert redirect and stall together, plus assert reset mid-sequence with pc=16'hFFFF -> redirect ignored and RAS unchanged; without reset, the wrap gives next fetch 16'h0000; with reset, fetch restarts at RESET_PC and flags clear.
